// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch (read-only) and data access (read/write).
// One transaction at a time; data has priority, with a starvation guard for fetch and a watchdog on missing acks.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    // fetch requester
    input  logic              i_f_req,
    input  logic [ADDR_W-1:0] i_f_addr,
    output logic [DATA_W-1:0] o_f_rdata,
    output logic              o_f_done,
    // data requester
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_d_done,
    output logic              o_err,
    output logic              o_stall_f_c,
    output logic              o_stall_m_c,
    // memory port
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack
);

    localparam int unsigned STK_W    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned TMO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TMO_EN   = (TIMEOUT > 0);
    localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_D,
        S_WAIT_F,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [STK_W-1:0]   r_streak;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  r_f_rdata;
    logic [DATA_W-1:0]  r_d_rdata;
    logic               r_f_done;
    logic               r_d_done;
    logic               r_err;

    state_t             w_state_nxt;
    logic [STK_W-1:0]   w_streak_nxt;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic               w_mem_req_nxt;
    logic               w_mem_we_nxt;
    logic [ADDR_W-1:0]  w_mem_addr_nxt;
    logic [DATA_W-1:0]  w_mem_wdata_nxt;
    logic [DATA_W-1:0]  w_f_rdata_nxt;
    logic [DATA_W-1:0]  w_d_rdata_nxt;
    logic               w_f_done_nxt;
    logic               w_d_done_nxt;
    logic               w_err_nxt;

    logic               w_starved;
    logic               w_grant_d;
    logic               w_expire;
    logic               w_is_data;

    // Fetch wins only once data has won STARVE_LIMIT contested grants in a row.
    assign w_starved = i_f_req && (r_streak == STK_W'(STARVE_LIMIT));
    assign w_grant_d = i_d_req && !w_starved;
    // An ack in the final watchdog cycle still completes normally.
    assign w_expire  = TMO_EN && (r_tmo == TMO_W'(TMO_LAST)) && !i_mem_ack;
    assign w_is_data = (r_state == S_WAIT_D);

    always_comb begin
        w_state_nxt     = r_state;
        w_streak_nxt    = r_streak;
        w_tmo_nxt       = r_tmo;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_f_rdata_nxt   = r_f_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_f_done_nxt    = 1'b0;
        w_d_done_nxt    = 1'b0;
        w_err_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tmo_nxt = '0;
                if (w_grant_d) begin
                    w_state_nxt     = S_WAIT_D;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = i_d_we;
                    w_mem_addr_nxt  = i_d_addr;
                    w_mem_wdata_nxt = i_d_wdata;
                    if (!i_f_req) begin
                        w_streak_nxt = '0;
                    end else if (r_streak != STK_W'(STARVE_LIMIT)) begin
                        w_streak_nxt = r_streak + STK_W'(1);
                    end
                end else if (i_f_req) begin
                    w_state_nxt     = S_WAIT_F;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = i_f_addr;
                    w_mem_wdata_nxt = '0;
                    w_streak_nxt    = '0;
                end
            end

            S_WAIT_D, S_WAIT_F: begin
                if (i_mem_ack || w_expire) begin
                    w_state_nxt   = S_RESP;
                    w_mem_req_nxt = 1'b0;
                    w_err_nxt     = w_expire;
                    if (w_is_data) begin
                        w_d_done_nxt = 1'b1;
                        if (!r_mem_we) begin
                            w_d_rdata_nxt = w_expire ? '0 : i_mem_rdata;
                        end
                    end else begin
                        w_f_done_nxt  = 1'b1;
                        w_f_rdata_nxt = w_expire ? '0 : i_mem_rdata;
                    end
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end

            S_RESP: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_streak    <= '0;
            r_tmo       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_f_rdata   <= '0;
            r_d_rdata   <= '0;
            r_f_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_streak    <= w_streak_nxt;
            r_tmo       <= w_tmo_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_f_rdata   <= w_f_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_f_done    <= w_f_done_nxt;
            r_d_done    <= w_d_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign o_f_rdata   = r_f_rdata;
    assign o_f_done    = r_f_done;
    assign o_d_rdata   = r_d_rdata;
    assign o_d_done    = r_d_done;
    assign o_err       = r_err;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

    // Pipeline stalls release in the same cycle the done pulse arrives.
    assign o_stall_f_c = i_f_req && !r_f_done;
    assign o_stall_m_c = i_d_req && !r_d_done;

endmodule
